vram_fill_ctrl: RTL

- Rectangle-fill controller for the 640x480, 12-bit-colour frame buffer.
- Accepts a fill command (corner coordinates plus colour) over a valid/ready handshake.
- Walks the rectangle in raster order and drives the frame buffer write port, one pixel per enabled cycle.
- Shares the single-ported frame buffer with the VGA scan-out: when BLANK_ONLY=1 it writes only while the display controller's active-low read strobe rdn is high (blanking).

---
 rtl/vram_fill_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: raster-order rectangle fill of a frame buffer shared with VGA scan-out.
module vram_fill_ctrl #(
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [11:0] color,
  input  logic        abort,
  input  logic        rdn,
  output logic        we,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [18:0] pix_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam logic [9:0] X_MAX = 10'(H_PIX - 1);
  localparam logic [8:0] Y_MAX = 9'(V_PIX - 1);
  state_t      state_q;
  logic [9:0]  x0_q, cx1_q, col_q;
  logic [8:0]  cy1_q, row_q;
  logic [11:0] color_q;
  logic [18:0] pix_q;
  logic        err_q;
  logic [9:0]  cx1;
  logic [8:0]  cy1;
  logic        empty, gate, last_col, last_row;
  assign cx1      = (x1 > X_MAX) ? X_MAX : x1;
  assign cy1      = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty    = ({1'b0, x0} >= 11'(H_PIX)) || ({1'b0, y0} >= 10'(V_PIX)) || (x0 > cx1) || (y0 > cy1);
  // scan-out owns the buffer while rdn is low
  assign gate     = !BLANK_ONLY || rdn;
  assign last_col = col_q == cx1_q;
  assign last_row = row_q == cy1_q;
  assign we        = (state_q == FILL) && gate && !abort;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign wr_row    = row_q;
  assign wr_col    = col_q;
  assign wr_data   = color_q;
  assign pix_cnt   = pix_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      x0_q    <= '0;
      cx1_q   <= '0;
      cy1_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          x0_q    <= x0;
          cx1_q   <= cx1;
          cy1_q   <= cy1;
          col_q   <= x0;
          row_q   <= y0;
          color_q <= color;
          pix_q   <= '0;
          err_q   <= empty;
          state_q <= empty ? DONE : FILL;
        end
        FILL: if (abort) begin
          err_q   <= 1'b1;
          state_q <= DONE;
        end else if (gate) begin
          pix_q <= pix_q + 19'd1;
          if (last_col && last_row) begin
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (last_col) begin
            col_q <= x0_q;
            row_q <= row_q + 9'd1;
          end else begin
            col_q <= col_q + 10'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
